bchecc_enc_mp: RTL and testbench

BCHECC_ENC_MP -- requirements
Module: bchecc_enc_mp

---
 rtl/bchecc_pkg.sv | 16 +
 rtl/bchecc_par_upd.sv | 19 +
 rtl/bchecc_enc_mp.sv | 94 +++++++++
 tb/tb_bchecc_enc_mp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bchecc_pkg.sv
// bchecc_pkg: FSM states and per-mode code tables (parity length, message words, reflected generator).
package bchecc_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, PAR} state_t;
   localparam int GW = 195;
   localparam int KW = 16;
   localparam logic [195:0] G0 = 196'h59A7A9C6E291DE47EBBAAE07E6B438E89058613FE6BED40CC;
   localparam int MODE_P [4] = '{195, 104, 64, 32};
   localparam int MODE_K [4] = '{512, 128, 64, 32};
   // Reflected generators: bit 0 is the highest-order tap, so r shifts right.
   localparam logic [GW-1:0] MODE_GEN [4] = '{
      G0[GW-1:0],
      GW'(104'hC4DF23A382E1C830DE07289FA8),
      GW'(64'hC96C5795D7870F42),
      GW'(32'hEDB88320)
   };
endpackage

// File: rtl/bchecc_par_upd.sv
// bchecc_par_upd: folds one DW-bit word into the reflected parity LFSR, bit 0 first.
module bchecc_par_upd #(
   parameter int DW = 8,
   parameter int PMAX = 195
) (
   input  logic [PMAX-1:0] r,
   input  logic [DW-1:0]   d,
   input  logic [PMAX-1:0] gen,
   input  logic [15:0]     p,
   output logic [PMAX-1:0] r_next
);
   logic [PMAX-1:0] mask;
   always_comb begin
      mask = ~({PMAX{1'b1}} << p);
      r_next = r & mask;
      for (int b = 0; b < DW; b++)
         r_next = ((r_next >> 1) ^ ({PMAX{d[b] ^ r_next[0]}} & gen)) & mask;
   end
endmodule

// File: rtl/bchecc_enc_mp.sv
// bchecc_enc_mp: multi-mode systematic BCH encoder; message words pass through, then parity words follow.
module bchecc_enc_mp
   import bchecc_pkg::*;
#(
   parameter int DW = 8,
   parameter int NMODE = 2,
   parameter int PMAX = 195
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [1:0]    mode_i,
   input  logic          abort_i,
   input  logic [DW-1:0] din_i,
   input  logic          din_vld_i,
   output logic          din_rdy_o,
   output logic [DW-1:0] dout_o,
   output logic          dout_vld_o,
   input  logic          dout_rdy_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o
);
   state_t          state, state_nx;
   logic [1:0]      mode;
   logic [PMAX-1:0] r, r_upd, gen_cur;
   logic [KW-1:0]   cnt, np_cur;
   logic [DW-1:0]   last_mask;
   int              p_cur;
   logic            slot_free, acc, pop, fin, mode_ok, start_ok;

   bchecc_par_upd #(.DW(DW), .PMAX(PMAX)) u_upd (
      .r(r),
      .d(din_i),
      .gen(gen_cur),
      .p(16'(p_cur)),
      .r_next(r_upd)
   );

   always_comb begin
      gen_cur = PMAX'(MODE_GEN[mode]);
      p_cur = MODE_P[mode];
      np_cur = KW'((p_cur + DW - 1) / DW);
      last_mask = (p_cur % DW == 0) ? '1 : ~({DW{1'b1}} << (p_cur % DW));
      slot_free = !dout_vld_o || dout_rdy_i;
      busy_o = state != IDLE;
      din_rdy_o = state == LOAD && slot_free;
      acc = din_vld_i && din_rdy_o;
      pop = state == PAR && slot_free && cnt != '0;
      fin = state == PAR && cnt == '0 && dout_vld_o && dout_rdy_i;
      mode_ok = int'(mode_i) < NMODE;
      start_ok = state == IDLE && start_i && mode_ok;
      state_nx = abort_i ? IDLE :
                 start_ok ? LOAD :
                 (acc && cnt == KW'(1)) ? PAR :
                 fin ? IDLE : state;
   end

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;

   // Abort shares the reset path so no partial codeword or done pulse survives it.
   always_ff @(posedge clk) begin
      if (rst || abort_i) begin
         mode <= '0;
         r <= '0;
         cnt <= '0;
         dout_o <= '0;
         dout_vld_o <= 1'b0;
         done_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         done_o <= fin;
         err_o <= state == IDLE && start_i && !mode_ok;
         if (start_ok) begin
            mode <= mode_i;
            r <= '0;
            cnt <= KW'(MODE_K[mode_i]);
         end else if (acc) begin
            r <= r_upd;
            dout_o <= din_i;
            dout_vld_o <= 1'b1;
            cnt <= (cnt == KW'(1)) ? np_cur : cnt - KW'(1);
         end else if (pop) begin
            dout_o <= r[DW-1:0] & ((cnt == KW'(1)) ? last_mask : '1);
            dout_vld_o <= 1'b1;
            r <= r >> DW;
            cnt <= cnt - KW'(1);
         end else if (dout_vld_o && dout_rdy_i) begin
            dout_vld_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bchecc_enc_mp.sv
// tb_bchecc_enc_mp: hand-computed parity vector table plus abort, reset, error and backpressure sequences.
module tb_bchecc_enc_mp;
   localparam int BIG = 100000;
   localparam logic [199:0] G0 = 200'h59A7A9C6E291DE47EBBAAE07E6B438E89058613FE6BED40CC;
   localparam logic [199:0] G1 = 200'hC4DF23A382E1C830DE07289FA8;
   localparam logic [199:0] G1S = 200'h626F91D1C170E4186F03944FD4;

   logic clk = 1'b0;
   logic rst, start_i, abort_i, din_vld_i, din_rdy_o, dout_vld_o, dout_rdy_i, busy_o, done_o, err_o;
   logic [1:0] mode_i;
   logic [7:0] din_i, dout_o;
   int checks = 0;
   int errors = 0;
   logic [7:0] msg [512];
   logic [7:0] got [600];
   logic [7:0] ref_got [600];
   int wi, ngot, fin;
   logic held;
   logic [7:0] hv;

   typedef struct {
      logic [1:0]   m;
      int           pos;
      logic [7:0]   val;
      logic [199:0] exp;
   } vec_t;
   vec_t tv [6];

   always #5 clk = ~clk;

   bchecc_enc_mp #(.DW(8), .NMODE(2), .PMAX(195)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
      .din_i(din_i), .din_vld_i(din_vld_i), .din_rdy_o(din_rdy_o),
      .dout_o(dout_o), .dout_vld_o(dout_vld_o), .dout_rdy_i(dout_rdy_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_chk(input string nm);
      chk(nm, {dout_vld_o, dout_o, din_rdy_o, busy_o, done_o, err_o}, 0);
   endtask

   function automatic logic [199:0] model(input logic [1:0] m);
      logic [199:0] r, g;
      int k;
      g = (m == 0) ? G0 : G1;
      k = (m == 0) ? 512 : 128;
      r = '0;
      for (int w = 0; w < k; w++)
         for (int b = 0; b < 8; b++)
            r = (msg[w][b] ^ r[0]) ? ((r >> 1) ^ g) : (r >> 1);
      return r;
   endfunction

   task automatic clear_msg();
      for (int i = 0; i < 512; i++) msg[i] = 8'h00;
   endtask

   task automatic rand_msg();
      for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
   endtask

   // Drives one codeword; stops early after stop_w accepted words or stop_o consumed output words.
   task automatic run_cw(input logic [1:0] m, input bit bp, input int stop_w, input int stop_o);
      int k;
      logic a, t;
      k = (m == 0) ? 512 : 128;
      wi = 0; ngot = 0; fin = 0; held = 1'b0;
      @(negedge clk);
      start_i = 1'b1; mode_i = m; abort_i = 1'b0; din_vld_i = 1'b0; dout_rdy_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; mode_i = m ^ 2'd1;
      for (int c = 0; c < 3000; c++) begin
         if (done_o) begin
            fin = 1;
            break;
         end
         if (wi >= stop_w || ngot >= stop_o) break;
         if (held) chk("stall hold", {dout_vld_o, dout_o}, {1'b1, hv});
         din_vld_i = wi < k;
         din_i = (wi < k) ? msg[wi] : 8'h00;
         dout_rdy_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         a = din_vld_i && din_rdy_o;
         t = dout_vld_o && dout_rdy_i;
         held = dout_vld_o && !dout_rdy_i;
         hv = dout_o;
         if (t && ngot < 600) begin
            got[ngot] = dout_o;
            ngot++;
         end
         if (a) wi++;
         @(negedge clk);
      end
   endtask

   task automatic check_cw(input string nm, input logic [1:0] m, input logic [199:0] exp);
      int k, np, bad;
      k = (m == 0) ? 512 : 128;
      np = (m == 0) ? 25 : 13;
      chk({nm, " done seen"}, fin, 1);
      chk({nm, " busy at done"}, busy_o, 0);
      chk({nm, " word count"}, ngot, k + np);
      bad = 0;
      for (int i = 0; i < k; i++)
         if (got[i] !== msg[i] && bad == 0) bad = i + 1;
      chk({nm, " passthrough first bad idx+1"}, bad, 0);
      for (int j = 0; j < np; j++)
         chk($sformatf("%s parity%0d", nm, j), got[k + j], exp[8*j +: 8]);
      din_vld_i = 1'b0;
      dout_rdy_i = 1'b1;
      @(negedge clk);
      chk({nm, " done single pulse"}, {done_o, busy_o}, 0);
   endtask

   initial begin
      int nd;
      tv[0] = '{2'd0, 0, 8'h00, 200'h0};
      tv[1] = '{2'd0, 511, 8'h80, G0};
      tv[2] = '{2'd0, 511, 8'h40, G0 >> 1};
      tv[3] = '{2'd1, 127, 8'h80, G1};
      tv[4] = '{2'd1, 127, 8'h40, G1S};
      tv[5] = '{2'd1, 127, 8'hC0, G1 ^ G1S};

      rst = 1'b1; start_i = 1'b1; mode_i = 2'd0; abort_i = 1'b0;
      din_vld_i = 1'b1; din_i = 8'hA5; dout_rdy_i = 1'b1;
      repeat (3) @(negedge clk);
      idle_chk("reset state");
      rst = 1'b0; start_i = 1'b0; din_vld_i = 1'b0;
      @(negedge clk);
      idle_chk("after reset release");

      for (int i = 0; i < 6; i++) begin
         clear_msg();
         msg[tv[i].pos] = tv[i].val;
         run_cw(tv[i].m, 1'b0, BIG, BIG);
         check_cw($sformatf("vec%0d", i), tv[i].m, tv[i].exp);
      end

      clear_msg();
      msg[0] = 8'h01;
      run_cw(2'd0, 1'b0, BIG, BIG);
      check_cw("lead one", 2'd0, model(2'd0));
      chk("lead one last word top bits", got[536][7:3], 0);

      rand_msg();
      run_cw(2'd1, 1'b0, BIG, BIG);
      check_cw("random", 2'd1, model(2'd1));
      for (int i = 0; i < 141; i++) ref_got[i] = got[i];
      run_cw(2'd1, 1'b1, BIG, BIG);
      check_cw("random bp", 2'd1, model(2'd1));
      nd = 0;
      for (int i = 0; i < 141; i++) if (got[i] !== ref_got[i]) nd++;
      chk("bp stream differs words", nd, 0);

      rand_msg();
      run_cw(2'd1, 1'b0, 100, BIG);
      chk("abort word index", wi, 100);
      abort_i = 1'b1; start_i = 1'b1; mode_i = 2'd0; din_vld_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0; start_i = 1'b0; din_vld_i = 1'b0;
      chk("abort outputs", {dout_vld_o, busy_o, din_rdy_o, done_o, err_o}, 0);
      abort_i = 1'b1; start_i = 1'b1; mode_i = 2'd1;
      @(negedge clk);
      abort_i = 1'b0; start_i = 1'b0;
      chk("abort beats start", {busy_o, err_o}, 0);
      run_cw(2'd1, 1'b0, BIG, BIG);
      check_cw("after abort", 2'd1, model(2'd1));

      start_i = 1'b1; mode_i = 2'd3;
      @(negedge clk);
      start_i = 1'b0;
      chk("bad mode err pulse", {err_o, busy_o}, 2'b10);
      @(negedge clk);
      chk("bad mode err one cycle", {err_o, busy_o}, 0);

      rand_msg();
      run_cw(2'd1, 1'b0, BIG, 131);
      chk("in parity phase", {busy_o, din_rdy_o}, 2'b10);
      rst = 1'b1; start_i = 1'b1; abort_i = 1'b0;
      @(negedge clk);
      idle_chk("reset in parity");
      rst = 1'b0; start_i = 1'b0;
      run_cw(2'd1, 1'b0, BIG, BIG);
      check_cw("after reset", 2'd1, model(2'd1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
